// File: rtl/storage_dma_pkg.sv
// Shared types and helpers for the storage DMA responder.
//   dma_resp_state_e : responder FSM states
//   BEAT_BYTES       : bytes per 32-bit beat
//   tail_be()        : byte-enable mask for the final, partial beat
//   window_ok()      : request legality check against the served window
package storage_dma_pkg;

    localparam int BEAT_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_RD,
        ST_WR,
        ST_DONE
    } dma_resp_state_e;

    // tail == 0 means the last beat is full.
    function automatic logic [3:0] tail_be(input logic [1:0] tail);
        logic [3:0] be;
        be = (tail == 2'd0) ? 4'hF : ((4'd1 << tail) - 4'd1);
        return be;
    endfunction

    // All operands are 65 bits so addr+len and base+size cannot wrap.
    function automatic logic window_ok(input logic [64:0] addr,
                                       input logic [15:0] len,
                                       input logic [64:0] base,
                                       input logic [64:0] size);
        logic [64:0] last;
        last = addr + {49'd0, len};
        return (len != 16'd0) && (addr[1:0] == 2'b00) &&
               (addr >= base) && (last <= base + size);
    endfunction

endpackage

// File: rtl/storage_dma_responder_sync_fifo.sv
// Synchronous FIFO used as the beat buffer for both transfer directions.
// Ports: clk/rst, push+din, pop, dout (head, valid when !empty), full,
// empty, count (occupancy 0..DEPTH).
// Push and pop together never change the count: on a full FIFO the head
// leaves as the new beat enters; on an empty FIFO the beat bypasses to dout.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic                  pass, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_W);
    assign pass    = push && pop && empty;
    assign do_pop  = pop && !empty;
    assign do_push = push && !pass && (!full || pop);
    assign dout    = empty ? din : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/storage_dma_responder.sv
// Memory-side responder for the storage controller DMA port. Accepts one
// request (addr, length, direction), checks it against the buffer-SRAM
// window and streams beats through a small FIFO in either direction.
// Ports:
//   dma_*    : request/ack/error/done handshake plus the beat stream
//              (dma_valid/dma_ready meaning depends on direction)
//   mem_*    : SRAM request channel (req held until gnt, in-order rvalid)
//   xfer_count / err_count : saturating statistics, busy = not idle
module storage_dma_responder
    import storage_dma_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 64,
    parameter int          DATA_WIDTH  = 32,
    parameter int          MEM_AW      = 16,
    parameter logic [63:0] WINDOW_BASE = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [15:0]           dma_length,
    input  logic                  dma_write,
    output logic                  dma_ack,
    output logic                  dma_error,
    output logic                  dma_done,
    output logic                  dma_valid,
    input  logic                  dma_ready,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           xfer_count,
    output logic [31:0]           err_count,
    output logic                  busy
);
    localparam int          FCW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FCW:0] DEPTH_W = (FCW+1)'(FIFO_DEPTH);
    localparam logic [64:0] WIN_BASE = {1'b0, WINDOW_BASE};
    localparam logic [64:0] WIN_SIZE = 65'(BEAT_BYTES) << MEM_AW;

    dma_resp_state_e state, next;

    logic [14:0]     beats, issued, retired;
    logic [1:0]      tail;
    logic            is_write;
    logic            err_ack;
    logic [FCW-1:0]  outstanding;

    logic [64:0]     addr65;
    logic            accept, reject, rd_issue;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_din, fifo_dout;
    logic [FCW-1:0]  fifo_count;

    assign addr65 = {{(65-ADDR_WIDTH){1'b0}}, dma_addr};
    assign busy   = (state != ST_IDLE);

    // Reads are only issued while the FIFO has room for every beat already
    // in flight, so a returning rvalid can always be pushed.
    assign rd_issue = (state == ST_RD) && (issued < beats) &&
                      ({1'b0, fifo_count} + {1'b0, outstanding} < DEPTH_W);

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        next      = state;
        accept    = 1'b0;
        reject    = 1'b0;
        dma_ack   = err_ack;
        dma_error = err_ack;
        dma_done  = 1'b0;
        dma_valid = 1'b0;
        dma_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_wdata = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        fifo_din  = '0;
        case (state)
            ST_IDLE: begin
                // The cycle carrying an error ack still sees the old req
                // level; skip it so one request is not rejected twice.
                if (dma_req && !err_ack) begin
                    if (window_ok(addr65, dma_length, WIN_BASE, WIN_SIZE)) begin
                        accept = 1'b1;
                        next   = ST_ACK;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                dma_ack = 1'b1;
                next    = is_write ? ST_WR : ST_RD;
            end
            ST_RD: begin
                mem_req   = rd_issue;
                mem_be    = 4'hF;
                fifo_push = mem_rvalid;
                fifo_din  = mem_rdata;
                dma_valid = !fifo_empty;
                dma_rdata = fifo_dout;
                fifo_pop  = dma_valid && dma_ready;
                if (retired == beats) next = ST_DONE;
            end
            ST_WR: begin
                dma_valid = !fifo_full && (issued < beats);
                fifo_push = dma_valid && dma_ready;
                fifo_din  = dma_wdata;
                mem_req   = !fifo_empty;
                mem_we    = mem_req;
                mem_wdata = fifo_dout;
                mem_be    = (retired == beats - 15'd1) ? tail_be(tail) : 4'hF;
                fifo_pop  = mem_req && mem_gnt;
                if (retired == beats) next = ST_DONE;
            end
            ST_DONE: begin
                dma_done = 1'b1;
                next     = ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            err_ack     <= 1'b0;
            beats       <= '0;
            issued      <= '0;
            retired     <= '0;
            tail        <= '0;
            is_write    <= 1'b0;
            outstanding <= '0;
            mem_addr    <= '0;
            xfer_count  <= '0;
            err_count   <= '0;
        end else begin
            state   <= next;
            err_ack <= reject;
            if (reject && err_count != '1)
                err_count <= err_count + 32'd1;
            if (state == ST_DONE && xfer_count != '1)
                xfer_count <= xfer_count + 32'd1;

            if (accept) begin
                beats       <= 15'(({1'b0, dma_length} + 17'd3) >> 2);
                tail        <= dma_length[1:0];
                is_write    <= dma_write;
                mem_addr    <= MEM_AW'((addr65 - WIN_BASE) >> 2);
                issued      <= '0;
                retired     <= '0;
                outstanding <= '0;
            end

            if (mem_req && mem_gnt)
                mem_addr <= mem_addr + MEM_AW'(1);

            if (state == ST_RD) begin
                if (mem_req && mem_gnt) issued  <= issued + 15'd1;
                if (fifo_pop)           retired <= retired + 15'd1;
                case ({mem_req && mem_gnt, mem_rvalid})
                    2'b10:   outstanding <= outstanding + FCW'(1);
                    2'b01:   outstanding <= outstanding - FCW'(1);
                    default: ;
                endcase
            end

            if (state == ST_WR) begin
                if (fifo_push) issued  <= issued + 15'd1;
                if (fifo_pop)  retired <= retired + 15'd1;
            end
        end
    end

endmodule

// File: tb/tb_storage_dma_responder.sv
// Directed bench for storage_dma_responder: SRAM model with optional random
// grant, initiator with optional random ready, hand-computed expectations.
module tb_storage_dma_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_req;
    logic [63:0] dma_addr;
    logic [15:0] dma_length;
    logic        dma_write;
    logic        dma_ack, dma_error, dma_done, dma_valid;
    logic        dma_ready;
    logic [31:0] dma_rdata, dma_wdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] xfer_count, err_count;
    logic        busy;

    storage_dma_responder dut (
        .clk        (clk),
        .rst        (rst),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_length (dma_length),
        .dma_write  (dma_write),
        .dma_ack    (dma_ack),
        .dma_error  (dma_error),
        .dma_done   (dma_done),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_rdata  (dma_rdata),
        .dma_wdata  (dma_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .xfer_count (xfer_count),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Stimulus knobs, written only by the main initial block.
    bit          ready_rand, gnt_rand, cur_wr;
    logic [31:0] wtab [0:2];
    int          widx;

    // SRAM model: grant-gated, read data one cycle after grant.
    logic [31:0] sram [0:65535];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            mem_rvalid <= mem_req && mem_gnt && !mem_we;
            mem_rdata  <= sram[mem_addr];
            if (mem_req && mem_gnt && mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        mem_gnt   <= gnt_rand   ? 1'($urandom_range(0, 1)) : 1'b1;
        dma_ready <= ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cur_wr && dma_valid && dma_ready) widx <= widx + 1;
    end

    assign dma_wdata = (widx < 3) ? wtab[widx] : 32'h0;

    // Monitor, sampled mid-cycle.
    logic [31:0] rd_q [$];
    logic [15:0] wa_q [$];
    logic [3:0]  wbe_q [$];
    logic [31:0] wd_q [$];
    int done_cnt = 0, memreq_cyc = 0, gnts = 0, pops = 0, max_infl = 0;

    always @(negedge clk) begin
        if (dma_done) done_cnt++;
        if (mem_req)  memreq_cyc++;
        if (mem_req && mem_gnt && !mem_we) begin
            gnts++;
            if (gnts - pops > max_infl) max_infl = gnts - pops;
        end
        if (!cur_wr && dma_valid && dma_ready) begin
            rd_q.push_back(dma_rdata);
            pops++;
        end
        if (mem_req && mem_gnt && mem_we) begin
            wa_q.push_back(mem_addr);
            wbe_q.push_back(mem_be);
            wd_q.push_back(mem_wdata);
        end
    end

    // Drives one request; returns in the cycle after acceptance (N+1).
    task automatic issue(input logic [63:0] a, input logic [15:0] len,
                         input bit wr, input bit exp_err, input string tag);
        @(posedge clk); #1;
        dma_req = 1'b1; dma_addr = a; dma_length = len; dma_write = wr;
        @(posedge clk); #1;
        chk({tag, "_ack"}, dma_ack, 1'b1);
        chk({tag, "_err"}, dma_error, exp_err);
        dma_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(tag, done_cnt - d0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, m0, d0, k;
        rst = 1'b1; dma_req = 1'b0; dma_addr = '0; dma_length = '0; dma_write = 1'b0;
        ready_rand = 0; gnt_rand = 0; cur_wr = 0; widx = 0;
        for (int i = 0; i < 4; i++)  sram[i]      = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 16; i++) sram[64 + i] = 32'hC000_0000 + 32'(i);
        for (int i = 0; i < 8; i++)  sram[128 + i] = 32'hE000_0000 + 32'(i);
        sram[6]     = 32'hFFFF_FFFF;
        sram[65535] = 32'hDEAD_BEEF;
        wtab[0] = 32'hB0B0_0000; wtab[1] = 32'hB0B0_0001; wtab[2] = 32'hB0B0_0002;

        repeat (3) @(posedge clk); #1;
        chk("rst_ack", dma_ack, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_valid", dma_valid, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xfer", xfer_count, 0);
        chk("rst_errc", err_count, 0);
        @(negedge clk); rst = 1'b0;

        // 16 B read at window base
        base = rd_q.size();
        issue(64'h1000_0000, 16'd16, 1'b0, 1'b0, "rd16");
        @(posedge clk); #1;
        chk("rd16_memreq_n2", mem_req, 1);
        chk("rd16_addr_n2", mem_addr, 16'h0000);
        wait_done(200, "rd16_done");
        chk("rd16_beats", rd_q.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("rd16_data", rd_q[base + i], 32'hA000_0000 + 32'(i));
        chk("rd16_xfer", xfer_count, 1);

        // 10 B write at word 4
        base = wa_q.size();
        cur_wr = 1; widx = 0;
        issue(64'h1000_0010, 16'd10, 1'b1, 1'b0, "wr10");
        wait_done(200, "wr10_done");
        cur_wr = 0;
        chk("wr10_cnt", wa_q.size() - base, 3);
        chk("wr10_a0", wa_q[base],     16'd4);
        chk("wr10_a1", wa_q[base + 1], 16'd5);
        chk("wr10_a2", wa_q[base + 2], 16'd6);
        chk("wr10_be0", wbe_q[base],     4'hF);
        chk("wr10_be1", wbe_q[base + 1], 4'hF);
        chk("wr10_be2", wbe_q[base + 2], 4'h3);
        chk("wr10_d2", wd_q[base + 2], 32'hB0B0_0002);

        // readback of the written words; word 6 keeps its upper bytes
        base = rd_q.size();
        issue(64'h1000_0010, 16'd12, 1'b0, 1'b0, "rb");
        wait_done(200, "rb_done");
        chk("rb_w0", rd_q[base],     32'hB0B0_0000);
        chk("rb_w1", rd_q[base + 1], 32'hB0B0_0001);
        chk("rb_w2", rd_q[base + 2], 32'hFFFF_0002);
        chk("rb_xfer", xfer_count, 3);

        // 64 B read with random ready and grant
        base = rd_q.size();
        ready_rand = 1; gnt_rand = 1;
        issue(64'h1000_0100, 16'd64, 1'b0, 1'b0, "bp");
        wait_done(3000, "bp_done");
        ready_rand = 0; gnt_rand = 0;
        chk("bp_beats", rd_q.size() - base, 16);
        k = 0;
        for (int i = 0; i < 16; i++)
            if (rd_q[base + i] !== 32'hC000_0000 + 32'(i)) k++;
        chk("bp_order_errs", k, 0);
        chk("bp_inflight_le4", max_infl <= 4, 1);

        // rejected requests
        m0 = memreq_cyc;
        issue(64'h1000_0000, 16'd0, 1'b0, 1'b1, "err_len0");
        repeat (2) @(posedge clk);
        issue(64'h1000_0002, 16'd4, 1'b0, 1'b1, "err_align");
        repeat (2) @(posedge clk);
        issue(64'h1003_FFFC, 16'd8, 1'b0, 1'b1, "err_over");
        repeat (3) @(negedge clk);
        chk("err_memreq", memreq_cyc - m0, 0);
        chk("err_count", err_count, 3);
        chk("err_xfer", xfer_count, 4);
        chk("err_busy", busy, 0);

        // last word of the window
        base = rd_q.size();
        issue(64'h1003_FFFC, 16'd4, 1'b0, 1'b0, "edge");
        @(posedge clk); #1;
        chk("edge_memreq", mem_req, 1);
        chk("edge_addr", mem_addr, 16'hFFFF);
        wait_done(200, "edge_done");
        chk("edge_data", rd_q[base], 32'hDEAD_BEEF);

        // reset mid-read after two beats
        base = rd_q.size();
        ready_rand = 1;
        issue(64'h1000_0200, 16'd32, 1'b0, 1'b0, "mid");
        for (int i = 0; i < 500 && rd_q.size() < base + 2; i++) @(negedge clk);
        chk("mid_two_beats", rd_q.size() - base >= 2, 1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", dma_valid, 0);
        chk("mid_rst_memreq", mem_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_xfer", xfer_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; ready_rand = 0;
        repeat (4) @(negedge clk);
        chk("mid_no_done", done_cnt - d0, 0);

        base = rd_q.size();
        issue(64'h1000_0000, 16'd4, 1'b0, 1'b0, "post");
        wait_done(200, "post_done");
        chk("post_data", rd_q[base], 32'hA000_0000);
        chk("post_xfer", xfer_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
